// File: rtl/avl_adc_reader_if.sv
// Avalon-MM read bus towards the ADC responder plus the sample stream
// towards the downstream consumer, bundled as one port of avl_adc_reader.
interface avl_adc_reader_if;
   logic [9:0]  avm_address;
   logic        avm_read;
   logic        avm_burstcount;
   logic [15:0] avm_readdata;
   logic        avm_waitrequest;
   logic        avm_readdatavalid;
   logic [15:0] smp_data;
   logic        smp_valid;
   logic        smp_ready;

   // Reader side: issues reads, sources the sample stream.
   modport master (
      output avm_address,
      output avm_read,
      output avm_burstcount,
      input  avm_readdata,
      input  avm_waitrequest,
      input  avm_readdatavalid,
      output smp_data,
      output smp_valid,
      input  smp_ready
   );

   // Responder / consumer side.
   modport slave (
      input  avm_address,
      input  avm_read,
      input  avm_burstcount,
      output avm_readdata,
      output avm_waitrequest,
      output avm_readdatavalid,
      input  smp_data,
      input  smp_valid,
      output smp_ready
   );
endinterface

// File: rtl/avl_adc_reader.sv
// Avalon-MM ADC read master. On start it issues `count` single-word reads
// to a fixed address, one outstanding at a time, stores the returned
// samples in a first-word-fall-through FIFO and streams them out on a
// valid/ready interface. Supports abort and a per-state response timeout.
module avl_adc_reader #(
   parameter logic [9:0] ADDR    = 10'h000,
   parameter int         DEPTH   = 16,
   parameter int         TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [9:0]       count,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             err,
   avl_adc_reader_if.master bus
);

   localparam int              AW        = $clog2(DEPTH);
   localparam logic [AW:0]     OCC_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]     OCC_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
   localparam logic [15:0]     TIMER_MAX = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_REQ,
      S_WAIT
   } state_t;

   state_t      state_q;
   logic [9:0]  remaining_q;
   logic [15:0] timer_q;
   logic        abort_pending_q;
   logic        avm_read_q;
   logic        done_q;
   logic        err_q;

   // FIFO storage and bookkeeping
   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   occ_q, occ_d;
   logic          push;
   logic          pop;
   logic          smp_valid_w;
   logic          fifo_has_room;

   // Only a response that arrives while waiting for one is stored; strays
   // in any other state are dropped here.
   assign push          = (state_q == S_WAIT) && bus.avm_readdatavalid;
   assign smp_valid_w   = (occ_q != '0);
   assign pop           = smp_valid_w && bus.smp_ready;
   assign fifo_has_room = (occ_q < OCC_FULL);

   // Next-state of FIFO pointers and occupancy from push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
         occ_d = occ_q + OCC_ONE;
      end else if (pop && !push) begin
         occ_d = occ_q - OCC_ONE;
      end
   end

   // FIFO pointer and occupancy registers; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Sample storage; no reset needed since the head is masked when empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.avm_readdata;
      end
   end

   // Capture sequencer: IDLE -> HOLD -> REQ -> WAIT -> HOLD ... -> IDLE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         remaining_q     <= '0;
         timer_q         <= '0;
         abort_pending_q <= 1'b0;
         avm_read_q      <= 1'b0;
         done_q          <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               abort_pending_q <= 1'b0;
               if (start) begin
                  remaining_q <= count;
                  err_q       <= 1'b0;
                  timer_q     <= '0;
                  if (count == 10'd0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= S_HOLD;
                  end
               end
            end

            S_HOLD: begin
               // Abort is acted on here directly since nothing is in flight.
               if (abort) begin
                  done_q          <= 1'b1;
                  abort_pending_q <= 1'b0;
                  state_q         <= S_IDLE;
               end else if (fifo_has_room) begin
                  avm_read_q <= 1'b1;
                  timer_q    <= '0;
                  state_q    <= S_REQ;
               end
            end

            S_REQ: begin
               // A posted request cannot be withdrawn, so abort is deferred.
               if (abort) begin
                  abort_pending_q <= 1'b1;
               end
               if (!bus.avm_waitrequest) begin
                  avm_read_q <= 1'b0;
                  timer_q    <= '0;
                  state_q    <= S_WAIT;
               end else if (timer_q == TIMER_MAX) begin
                  err_q           <= 1'b1;
                  done_q          <= 1'b1;
                  avm_read_q      <= 1'b0;
                  abort_pending_q <= 1'b0;
                  state_q         <= S_IDLE;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end

            S_WAIT: begin
               if (abort) begin
                  abort_pending_q <= 1'b1;
               end
               if (bus.avm_readdatavalid) begin
                  remaining_q <= remaining_q - 10'd1;
                  if ((remaining_q == 10'd1) || abort_pending_q || abort) begin
                     done_q          <= 1'b1;
                     abort_pending_q <= 1'b0;
                     state_q         <= S_IDLE;
                  end else begin
                     state_q <= S_HOLD;
                  end
               end else if (timer_q == TIMER_MAX) begin
                  err_q           <= 1'b1;
                  done_q          <= 1'b1;
                  abort_pending_q <= 1'b0;
                  state_q         <= S_IDLE;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end

            default: begin
               avm_read_q <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign err  = err_q;

   assign bus.avm_read       = avm_read_q;
   assign bus.avm_address    = avm_read_q ? ADDR : 10'h000;
   assign bus.avm_burstcount = 1'b1;
   assign bus.smp_valid      = smp_valid_w;
   assign bus.smp_data       = smp_valid_w ? mem_q[rd_ptr_q] : 16'h0000;

endmodule

// File: tb/tb_avl_adc_reader.sv
// Directed testbench for avl_adc_reader (DEPTH=4, TIMEOUT=8) with a
// scripted Avalon responder and stream consumer.
module tb_avl_adc_reader;

   localparam logic [9:0] P_ADDR = 10'h2A5;

   logic       clk;
   logic       reset;
   logic       start;
   logic [9:0] count;
   logic       abort;
   logic       busy;
   logic       done;
   logic       err;

   avl_adc_reader_if bus_if ();

   avl_adc_reader #(
      .ADDR    (P_ADDR),
      .DEPTH   (4),
      .TIMEOUT (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .count (count),
      .abort (abort),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .bus   (bus_if.master)
   );

   int total = 0;
   int bad   = 0;

   // Responder configuration (written by tests only)
   int   rsp_lat   = 2;
   int   stall_n   = 0;
   logic rsp_en    = 1'b1;
   int   stray_req = 0;

   // Responder state (written by the responder only)
   logic [15:0] rsp_seq    = 16'h0000;
   int          stall_left = 0;
   logic        pend       = 1'b0;
   int          pend_cnt   = 0;
   int          stray_done = 0;

   // Monitor state (written by monitor only)
   int          acc_cnt  = 0;
   int          done_cnt = 0;
   logic [15:0] popped[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Responder: acts 1 time unit after each rising edge.
   initial begin
      bus_if.avm_waitrequest   = 1'b0;
      bus_if.avm_readdatavalid = 1'b0;
      bus_if.avm_readdata      = 16'h0000;
      forever begin
         @(posedge clk);
         #1;
         bus_if.avm_readdatavalid = 1'b0;
         if (pend) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
               pend = 1'b0;
               bus_if.avm_readdatavalid = 1'b1;
               bus_if.avm_readdata      = rsp_seq;
               rsp_seq = rsp_seq + 16'd1;
            end
         end
         if (stray_req != stray_done) begin
            stray_done = stray_req;
            bus_if.avm_readdatavalid = 1'b1;
            bus_if.avm_readdata      = 16'hDEAD;
         end
         if (bus_if.avm_read === 1'b1) begin
            if (stall_left > 0) begin
               bus_if.avm_waitrequest = 1'b1;
               stall_left = stall_left - 1;
            end else begin
               bus_if.avm_waitrequest = 1'b0;
               stall_left = stall_n;
               if (rsp_en) begin
                  pend     = 1'b1;
                  pend_cnt = rsp_lat;
               end
            end
         end else begin
            bus_if.avm_waitrequest = 1'b0;
            stall_left = stall_n;
         end
      end
   end

   // Monitor: counts accepted reads, done pulses and records popped samples.
   always @(negedge clk) begin
      if (reset === 1'b1 && bus_if.avm_read === 1'b1 && bus_if.avm_waitrequest === 1'b0)
         acc_cnt <= acc_cnt + 1;
      if (done === 1'b1)
         done_cnt <= done_cnt + 1;
      if (reset === 1'b1 && bus_if.smp_valid === 1'b1 && bus_if.smp_ready === 1'b1) begin
         popped.push_back(bus_if.smp_data);
         $display("pop data=%h", bus_if.smp_data);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; count = 10'd0; abort = 1'b0;
      bus_if.smp_ready = 1'b0;
      repeat (3) step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      total++; if (bus_if.avm_read !== 1'b0) begin bad++; $display("FAIL reset_read got=%b exp=0", bus_if.avm_read); end
      total++; if (bus_if.avm_address !== 10'h000) begin bad++; $display("FAIL reset_addr got=%h exp=000", bus_if.avm_address); end
      total++; if (bus_if.avm_burstcount !== 1'b1) begin bad++; $display("FAIL reset_burst got=%b exp=1", bus_if.avm_burstcount); end
      total++; if (bus_if.smp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus_if.smp_valid); end
      total++; if (bus_if.smp_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", bus_if.smp_data); end
      reset = 1'b1;
      step();
      $display("test_reset complete");
   endtask

   task automatic test_basic();
      int k; int pb; int ab; int db;
      rsp_en = 1'b1; rsp_lat = 2; stall_n = 0; bus_if.smp_ready = 1'b1;
      pb = popped.size(); ab = acc_cnt; db = done_cnt;
      start = 1'b1; count = 10'd3; step(); start = 1'b0;   // cycle 1: HOLD
      total++; if (bus_if.avm_read !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_hold read=%b busy=%b exp read=0 busy=1", bus_if.avm_read, busy); end
      step();                                               // cycle 2: REQ
      total++; if (bus_if.avm_read !== 1'b1 || bus_if.avm_address !== P_ADDR) begin bad++; $display("FAIL basic_req read=%b addr=%h exp read=1 addr=%h", bus_if.avm_read, bus_if.avm_address, P_ADDR); end
      k = 2;
      while (done !== 1'b1 && k < 40) begin step(); k++; end
      total++; if (k != 13) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=13", k); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
      repeat (3) step();
      total++; if (acc_cnt - ab != 3) begin bad++; $display("FAIL basic_reads got=%0d exp=3", acc_cnt - ab); end
      total++; if (done_cnt - db != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - db); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", err); end
      total++; if (popped.size() - pb != 3) begin bad++; $display("FAIL basic_pop_count got=%0d exp=3", popped.size() - pb); end
      for (int i = 0; i < 3 && pb + i < popped.size(); i++) begin
         total++; if (popped[pb+i] !== 16'(i)) begin bad++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, popped[pb+i], 16'(i)); end
      end
      $display("test_basic complete");
   endtask

   task automatic test_backpressure();
      int k; int pb; int ab; int db; logic [15:0] d0;
      rsp_en = 1'b1; rsp_lat = 2; stall_n = 0; bus_if.smp_ready = 1'b0;
      pb = popped.size(); ab = acc_cnt; db = done_cnt; d0 = rsp_seq;
      start = 1'b1; count = 10'd10; step(); start = 1'b0;
      repeat (60) step();
      total++; if (acc_cnt - ab != 4) begin bad++; $display("FAIL bp_reads_full got=%0d exp=4", acc_cnt - ab); end
      total++; if (bus_if.avm_read !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL bp_hold read=%b busy=%b exp read=0 busy=1", bus_if.avm_read, busy); end
      total++; if (bus_if.smp_valid !== 1'b1 || bus_if.smp_data !== d0) begin bad++; $display("FAIL bp_head valid=%b data=%h exp valid=1 data=%h", bus_if.smp_valid, bus_if.smp_data, d0); end
      total++; if (done_cnt - db != 0) begin bad++; $display("FAIL bp_early_done got=%0d exp=0", done_cnt - db); end
      bus_if.smp_ready = 1'b1;
      k = 0;
      while (done !== 1'b1 && k < 200) begin step(); k++; end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done_timeout waited=%0d exp done=1", k); end
      repeat (4) step();
      total++; if (acc_cnt - ab != 10) begin bad++; $display("FAIL bp_reads got=%0d exp=10", acc_cnt - ab); end
      total++; if (done_cnt - db != 1) begin bad++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt - db); end
      total++; if (popped.size() - pb != 10) begin bad++; $display("FAIL bp_pop_count got=%0d exp=10", popped.size() - pb); end
      for (int i = 0; i < 10 && pb + i < popped.size(); i++) begin
         total++; if (popped[pb+i] !== d0 + 16'(i)) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, popped[pb+i], d0 + 16'(i)); end
      end
      total++; if (bus_if.smp_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", bus_if.smp_valid); end
      $display("test_backpressure complete");
   endtask

   task automatic test_stall();
      int k; int pb; int ab; int db; logic [15:0] d0;
      rsp_en = 1'b1; rsp_lat = 2; stall_n = 5; bus_if.smp_ready = 1'b1;
      pb = popped.size(); ab = acc_cnt; db = done_cnt; d0 = rsp_seq;
      start = 1'b1; count = 10'd1; step(); start = 1'b0;   // cycle 1
      step();                                               // cycle 2
      for (int c = 2; c <= 7; c++) begin
         total++;
         if (bus_if.avm_read !== 1'b1 || bus_if.avm_address !== P_ADDR || bus_if.avm_burstcount !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold cycle=%0d read=%b addr=%h burst=%b exp read=1 addr=%h burst=1", c, bus_if.avm_read, bus_if.avm_address, bus_if.avm_burstcount, P_ADDR);
         end
         step();
      end
      total++; if (bus_if.avm_read !== 1'b0 || bus_if.avm_address !== 10'h000) begin bad++; $display("FAIL stall_release read=%b addr=%h exp read=0 addr=000", bus_if.avm_read, bus_if.avm_address); end
      k = 0;
      while (done !== 1'b1 && k < 40) begin step(); k++; end
      repeat (3) step();
      total++; if (acc_cnt - ab != 1) begin bad++; $display("FAIL stall_reads got=%0d exp=1", acc_cnt - ab); end
      total++; if (done_cnt - db != 1) begin bad++; $display("FAIL stall_done_pulses got=%0d exp=1", done_cnt - db); end
      total++; if (popped.size() - pb != 1 || popped[popped.size()-1] !== d0) begin bad++; $display("FAIL stall_data n=%0d last=%h exp n=1 data=%h", popped.size() - pb, popped[popped.size()-1], d0); end
      stall_n = 0;
      $display("test_stall complete");
   endtask

   task automatic test_timeout();
      int k; int pb; int ab; int db; logic [15:0] d0;
      rsp_en = 1'b0; stall_n = 0; bus_if.smp_ready = 1'b0;
      pb = popped.size(); ab = acc_cnt; db = done_cnt; d0 = rsp_seq;
      start = 1'b1; count = 10'd2; step(); start = 1'b0;   // cycle 1
      k = 1;
      while (done !== 1'b1 && k < 40) begin step(); k++; end
      total++; if (k != 12) begin bad++; $display("FAIL timeout_done_cycle got=%0d exp=12", k); end
      total++; if (err !== 1'b1 || busy !== 1'b0 || bus_if.avm_read !== 1'b0) begin bad++; $display("FAIL timeout_flags err=%b busy=%b read=%b exp err=1 busy=0 read=0", err, busy, bus_if.avm_read); end
      step();
      total++; if (done !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL timeout_sticky done=%b err=%b exp done=0 err=1", done, err); end
      stray_req = stray_req + 1;
      repeat (3) step();
      total++; if (bus_if.smp_valid !== 1'b0) begin bad++; $display("FAIL timeout_stray_write valid=%b exp=0", bus_if.smp_valid); end
      total++; if (acc_cnt - ab != 1) begin bad++; $display("FAIL timeout_reads got=%0d exp=1", acc_cnt - ab); end
      rsp_en = 1'b1;
      start = 1'b1; count = 10'd1; step(); start = 1'b0;
      total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL timeout_err_clear err=%b busy=%b exp err=0 busy=1", err, busy); end
      k = 0;
      while (done !== 1'b1 && k < 40) begin step(); k++; end
      bus_if.smp_ready = 1'b1;
      repeat (3) step();
      total++; if (popped.size() - pb != 1 || popped[popped.size()-1] !== d0) begin bad++; $display("FAIL timeout_next_data n=%0d last=%h exp n=1 data=%h", popped.size() - pb, popped[popped.size()-1], d0); end
      total++; if (done_cnt - db != 2 || err !== 1'b0) begin bad++; $display("FAIL timeout_done_total got=%0d err=%b exp 2 err=0", done_cnt - db, err); end
      $display("test_timeout complete");
   endtask

   task automatic test_abort_zero();
      int k; int pb; int ab; int db; logic [15:0] d0;
      rsp_en = 1'b1; rsp_lat = 2; stall_n = 0; bus_if.smp_ready = 1'b0;
      pb = popped.size(); ab = acc_cnt; db = done_cnt; d0 = rsp_seq;
      start = 1'b1; count = 10'd5; step(); start = 1'b0;   // cycle 1
      repeat (6) step();                                    // cycle 7: WAIT of sample 2
      abort = 1'b1; step(); abort = 1'b0;                   // cycle 8
      k = 8;
      while (done !== 1'b1 && k < 40) begin step(); k++; end
      total++; if (k != 9) begin bad++; $display("FAIL abort_done_cycle got=%0d exp=9", k); end
      repeat (3) step();
      total++; if (acc_cnt - ab != 2 || busy !== 1'b0) begin bad++; $display("FAIL abort_reads got=%0d busy=%b exp 2 busy=0", acc_cnt - ab, busy); end
      total++; if (bus_if.smp_valid !== 1'b1 || bus_if.smp_data !== d0) begin bad++; $display("FAIL abort_head valid=%b data=%h exp valid=1 data=%h", bus_if.smp_valid, bus_if.smp_data, d0); end
      bus_if.smp_ready = 1'b1;
      repeat (4) step();
      total++; if (popped.size() - pb != 2) begin bad++; $display("FAIL abort_pop_count got=%0d exp=2", popped.size() - pb); end
      for (int i = 0; i < 2 && pb + i < popped.size(); i++) begin
         total++; if (popped[pb+i] !== d0 + 16'(i)) begin bad++; $display("FAIL abort_data[%0d] got=%h exp=%h", i, popped[pb+i], d0 + 16'(i)); end
      end
      ab = acc_cnt; db = done_cnt;
      start = 1'b1; count = 10'd0; step(); start = 1'b0;
      total++; if (done !== 1'b1 || busy !== 1'b0 || bus_if.avm_read !== 1'b0) begin bad++; $display("FAIL zero_done done=%b busy=%b read=%b exp done=1 busy=0 read=0", done, busy, bus_if.avm_read); end
      step();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_width got=%b exp=0", done); end
      repeat (5) step();
      total++; if (acc_cnt - ab != 0 || done_cnt - db != 1) begin bad++; $display("FAIL zero_activity reads=%0d dones=%0d exp 0 and 1", acc_cnt - ab, done_cnt - db); end
      $display("test_abort_zero complete");
   endtask

   task automatic test_reset_mid();
      int k; int pb; int db; logic [15:0] d1;
      rsp_en = 1'b1; rsp_lat = 2; stall_n = 0; bus_if.smp_ready = 1'b0;
      pb = popped.size();
      start = 1'b1; count = 10'd3; step(); start = 1'b0;   // cycle 1
      repeat (5) step();                                    // cycle 6: REQ of sample 2
      total++; if (bus_if.avm_read !== 1'b1 || bus_if.smp_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre read=%b valid=%b exp 1 1", bus_if.avm_read, bus_if.smp_valid); end
      reset = 1'b0; step();
      total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rmid_ctrl busy=%b done=%b err=%b exp 0 0 0", busy, done, err); end
      total++; if (bus_if.avm_read !== 1'b0 || bus_if.avm_address !== 10'h000) begin bad++; $display("FAIL rmid_bus read=%b addr=%h exp 0 000", bus_if.avm_read, bus_if.avm_address); end
      total++; if (bus_if.smp_valid !== 1'b0 || bus_if.smp_data !== 16'h0000) begin bad++; $display("FAIL rmid_fifo valid=%b data=%h exp 0 0000", bus_if.smp_valid, bus_if.smp_data); end
      reset = 1'b1;
      db = done_cnt;
      repeat (6) step();
      total++; if (bus_if.smp_valid !== 1'b0 || busy !== 1'b0 || done_cnt - db != 0) begin bad++; $display("FAIL rmid_lost valid=%b busy=%b dones=%0d exp 0 0 0", bus_if.smp_valid, busy, done_cnt - db); end
      d1 = rsp_seq;
      start = 1'b1; count = 10'd1; step(); start = 1'b0;   // cycle 1
      k = 1;
      while (done !== 1'b1 && k < 40) begin step(); k++; end
      total++; if (k != 5) begin bad++; $display("FAIL rmid_restart_done got=%0d exp=5", k); end
      bus_if.smp_ready = 1'b1;
      repeat (3) step();
      total++; if (popped.size() - pb != 1 || popped[popped.size()-1] !== d1) begin bad++; $display("FAIL rmid_restart_data n=%0d last=%h exp n=1 data=%h", popped.size() - pb, popped[popped.size()-1], d1); end
      $display("test_reset_mid complete");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_stall();
      test_timeout();
      test_abort_zero();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/avl_adc_reader.md
# avl_adc_reader

Avalon-MM read master that drives the ADC Avalon-MM responder (16-bit readdata, burstcount 1, waitrequest/readdatavalid pipelined reads). On a start pulse it issues a programmed number of single-word reads to a fixed sample address. It buffers returned samples in an internal first-word-fall-through FIFO and presents them on a valid/ready stream to the downstream consumer (RPi-side transfer logic). It is a single-read-outstanding initiator with a response timeout and abort.

## Interface
- ADDR, 10'h000, Avalon address driven on every read
- DEPTH, 16, FIFO depth in words; power of two, 2..256
- TIMEOUT, 1023, max cycles spent in REQ or WAIT before error; range 1..65535
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-low; all state cleared on the rising clk edge where reset==0
- start  in  1  one-cycle pulse; honoured only in IDLE
- count  in  10  number of samples to read, latched on start
- abort  in  1  terminates the current capture at the next safe point
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of capture (normal, zero count, abort or timeout)
- err  out  1  sticky timeout flag; cleared only by reset or by an accepted start
- avm_address  out  10  equals ADDR whenever avm_read==1, else 0
- avm_read  out  1  read request
- avm_burstcount  out  1  constant 1
- avm_readdata  in  16  response data
- avm_waitrequest  in  1  responder stall
- avm_readdatavalid  in  1  response strobe
- smp_data  out  16  FIFO head
- smp_valid  out  1  FIFO not empty
- smp_ready  in  1  consumer pop; a pop occurs when smp_valid && smp_ready

## Operation
- Reset values: busy=0, done=0, err=0, avm_read=0, avm_address=0, smp_valid=0, smp_data=0. FIFO is emptied, remaining=0, timer=0, state=IDLE.
- State machine:
  - IDLE: on start, latch remaining=count, clear err and timer. If count==0, pulse done and stay in IDLE. Otherwise go to HOLD.
  - HOLD: avm_read=0. If abort, pulse done and go to IDLE. Else, if FIFO occupancy < DEPTH, go to REQ.
  - REQ: avm_read=1, with address and burstcount held stable. A read is accepted on the cycle avm_read && !avm_waitrequest; it then goes to WAIT with timer=0. abort is ignored in REQ; a request must not be withdrawn.
  - WAIT: avm_read=0. On avm_readdatavalid, write avm_readdata into the FIFO and decrement remaining. If the new remaining==0 or abort_pending, pulse done and go to IDLE. Otherwise go to HOLD.
- abort seen in REQ or WAIT sets abort_pending. The capture then ends after the in-flight response arrives. abort_pending is cleared on entry to IDLE.
- Timeout: timer counts cycles in REQ and in WAIT, resetting on each state entry. When timer reaches TIMEOUT with no acceptance or response: set err, pulse done, drop avm_read, go to IDLE. A later stray readdatavalid in IDLE or HOLD is ignored, with no FIFO write.
- readdatavalid outside WAIT is always discarded.
- Flow control: reads are issued only when a FIFO slot is free. Because only one read is ever outstanding, the FIFO can never overflow.
- FIFO: FWFT, occupancy width log2(DEPTH)+1 bits, pointers wrap modulo DEPTH.
  - Simultaneous push and pop: occupancy is unchanged, and data order is preserved.
  - Pop on empty is ignored.
  - The FIFO contents survive done/IDLE; they are cleared only by reset.
- A start during busy is ignored.

## Timing
- Start accepted at edge 0: avm_read=1 from cycle 2 (via HOLD) when the FIFO has room.
- Zero-wait responder: the read is accepted in the first REQ cycle. A response in cycle k writes the FIFO at edge k, so smp_valid=1 in cycle k+1. The next avm_read is asserted in cycle k+2 (HOLD then REQ).
- Minimum issue interval is 4 cycles per sample: HOLD, REQ, ≥1 WAIT, response.
- done is asserted exactly one cycle, in the cycle after the final response edge or the timeout edge. busy falls in the same cycle as done.
- Timeout fires in the cycle where timer==TIMEOUT. The total REQ+WAIT dwell before error is therefore TIMEOUT+1 cycles per state.
- reset low mid-operation: avm_read drops at the next edge, and any in-flight response is lost.

## Test plan
- Basic capture: count=3, responder returns 16'h0000, 16'h0001, 16'h0002 with waitrequest low and 2-cycle read latency, smp_ready=1 → exactly 3 reads, smp_data sequence 0,1,2, one done pulse, err=0.
- Backpressure: DEPTH=4, count=10, smp_ready=0 → exactly 4 reads, then avm_read stays 0 in HOLD. Raising smp_ready lets all 10 samples drain in order, followed by a single done.
- Waitrequest stall: waitrequest high for 5 cycles → avm_read, avm_address=ADDR and burstcount=1 are held stable for all 6 cycles, and exactly one read is accepted.
- Timeout: TIMEOUT=8 with readdatavalid never asserted → err=1 and done pulses 9 cycles after acceptance. A stray readdatavalid afterwards leaves the FIFO unchanged. The next start clears err.
- Abort and zero count: abort in WAIT of sample 2 of 5 → sample 2 is stored, done fires, 2 samples are in the FIFO. start with count=0 → done on the next cycle with no avm_read.
- Reset mid-capture: reset=0 during REQ → all outputs are at reset values after the next edge, the FIFO is empty, and state is IDLE.
